coeff_tu_collect: RTL and testbench

- Downstream of the sign-restoration stage in the RDOQ pipeline.
- Consumes the stream of signed quantized coefficients (dst_coeff, out_pos, valid) for one transform unit (TU).
- Forwards each coefficient as a registered write to the external coefficient memory.
- Accumulates per-TU statistics for the entropy-coding front end: nonzero count, last significant scan index/position, and a 4x4 coefficient-group (CG) significance bitmap.

---
 rtl/rdoq_pkg.sv | 18 +
 rtl/cg_index_calc.sv | 36 +++
 rtl/coeff_tu_collect.sv | 173 +++++++++++++++++
 tb/tb_coeff_tu_collect.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdoq_pkg.sv
// Shared types and constants for the RDOQ coefficient pipeline stages.
package rdoq_pkg;

   localparam int COEFF_W       = 16;
   localparam int POS_W         = 10;
   localparam int MIN_LOG2_SIZE = 2;
   localparam int CG_LOG2       = 2;

   typedef logic signed [COEFF_W-1:0] coeff_t;
   typedef logic [POS_W-1:0]          pos_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_REPORT  = 2'd2
   } collect_state_e;

endpackage

// File: rtl/cg_index_calc.sv
// Maps a raster block position to its 4x4 coefficient-group index for a TU of
// side 1<<log2_size, and flags whether the position lies inside the TU.
module cg_index_calc
   import rdoq_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int NUM_CG     = 64
)(
   input  logic [ADDR_WIDTH-1:0]     pos,
   input  logic [2:0]                log2_size,
   output logic [$clog2(NUM_CG)-1:0] cg,
   output logic                      in_range
);

   localparam int CG_W = $clog2(NUM_CG);

   logic [ADDR_WIDTH-1:0] x_s;
   logic [ADDR_WIDTH-1:0] y_s;
   logic [ADDR_WIDTH-1:0] cg_full_s;
   logic [2:0]            cg_shift_s;

   // Split position into column/row, then pack the CG row/column into an index.
   always_comb begin
      x_s = pos & ((ADDR_WIDTH'(1) << log2_size) - ADDR_WIDTH'(1));
      y_s = pos >> log2_size;
      if (log2_size >= 3'(MIN_LOG2_SIZE)) begin
         cg_shift_s = log2_size - 3'(CG_LOG2);
      end else begin
         cg_shift_s = 3'd0;
      end
      cg_full_s = ((y_s >> CG_LOG2) << cg_shift_s) | (x_s >> CG_LOG2);
      cg        = cg_full_s[CG_W-1:0];
      in_range  = ((pos >> {log2_size, 1'b0}) == '0);
   end

endmodule

// File: rtl/coeff_tu_collect.sv
// Collects one TU of signed quantized coefficients: forwards each as a memory
// write and gathers entropy-coding statistics. COLLECT_ABSSUM_EN adds abs_sum.
module coeff_tu_collect
   import rdoq_pkg::*;
#(
   parameter int COEFF_WIDTH   = 16,
   parameter int ADDR_WIDTH    = 10,
   parameter int MAX_LOG2_SIZE = 5,
   parameter int NUM_CG        = 64
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tu_start,
   input  logic [2:0]                    log2_size,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [COEFF_WIDTH-1:0] in_coeff,
   input  logic [ADDR_WIDTH-1:0]         in_pos,
   output logic                          wr_en,
   output logic [ADDR_WIDTH-1:0]         wr_addr,
   output logic [COEFF_WIDTH-1:0]        wr_data,
   output logic                          tu_done,
   output logic                          tu_err,
   output logic [ADDR_WIDTH:0]           nz_count,
   output logic [ADDR_WIDTH-1:0]         last_scan,
   output logic [ADDR_WIDTH-1:0]         last_pos,
   output logic [NUM_CG-1:0]             cg_sig
`ifdef COLLECT_ABSSUM_EN
  ,output logic [ADDR_WIDTH+COEFF_WIDTH-1:0] abs_sum
`endif
);

   localparam int CG_W = $clog2(NUM_CG);

   collect_state_e        state_r;
   logic [2:0]            log2_r;
   logic [ADDR_WIDTH-1:0] scan_r;
   logic [ADDR_WIDTH-1:0] last_idx_r;
   logic                  err_r;
   logic                  beat_s;
   logic                  nonzero_s;
   logic                  size_ok_s;
   logic                  in_range_s;
   logic [CG_W-1:0]       cg_s;
   logic [ADDR_WIDTH:0]   expected_s;

`ifdef COLLECT_ABSSUM_EN
   // The most negative value has no positive twin; clamp it to the largest positive.
   function automatic logic [COEFF_WIDTH-1:0] abs_sat(input logic signed [COEFF_WIDTH-1:0] v);
      logic [COEFF_WIDTH-1:0] r;
      if (v == {1'b1, {(COEFF_WIDTH-1){1'b0}}}) begin
         r = {1'b0, {(COEFF_WIDTH-1){1'b1}}};
      end else if (v[COEFF_WIDTH-1]) begin
         r = -v;
      end else begin
         r = v;
      end
      return r;
   endfunction
`endif

   cg_index_calc #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_CG     (NUM_CG)
   ) u_cg_index_calc (
      .pos       (in_pos),
      .log2_size (log2_r),
      .cg        (cg_s),
      .in_range  (in_range_s)
   );

   // Handshake, zero test and size validation for the current cycle.
   always_comb begin
      beat_s     = in_valid && in_ready;
      nonzero_s  = (in_coeff != '0);
      size_ok_s  = (log2_size >= 3'(MIN_LOG2_SIZE)) && (log2_size <= 3'(MAX_LOG2_SIZE));
      expected_s = (ADDR_WIDTH+1)'(1) << {log2_size, 1'b0};
   end

   // TU sequencing, memory write path and statistics accumulation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         log2_r     <= 3'd0;
         scan_r     <= '0;
         last_idx_r <= '0;
         err_r      <= 1'b0;
         in_ready   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         tu_done    <= 1'b0;
         tu_err     <= 1'b0;
         nz_count   <= '0;
         last_scan  <= '0;
         last_pos   <= '0;
         cg_sig     <= '0;
`ifdef COLLECT_ABSSUM_EN
         abs_sum    <= '0;
`endif
      end else begin
         wr_en   <= beat_s;
         tu_done <= 1'b0;
         if (beat_s) begin
            wr_addr <= in_pos;
            wr_data <= in_coeff;
         end
         case (state_r)
            ST_IDLE: begin
               if (tu_start) begin
                  log2_r     <= log2_size;
                  scan_r     <= '0;
                  last_idx_r <= ADDR_WIDTH'(expected_s - (ADDR_WIDTH+1)'(1));
                  tu_err     <= 1'b0;
                  nz_count   <= '0;
                  last_scan  <= '0;
                  last_pos   <= '0;
                  cg_sig     <= '0;
`ifdef COLLECT_ABSSUM_EN
                  abs_sum    <= '0;
`endif
                  if (size_ok_s) begin
                     state_r  <= ST_COLLECT;
                     in_ready <= 1'b1;
                     err_r    <= 1'b0;
                  end else begin
                     state_r  <= ST_REPORT;
                     err_r    <= 1'b1;
                  end
               end
            end
            ST_COLLECT: begin
               // A restart request mid-TU aborts; upstream re-issues the start.
               if (tu_start) begin
                  state_r  <= ST_REPORT;
                  in_ready <= 1'b0;
                  err_r    <= 1'b1;
               end else if (beat_s) begin
                  scan_r <= scan_r + ADDR_WIDTH'(1);
                  if (nonzero_s) begin
                     nz_count  <= nz_count + (ADDR_WIDTH+1)'(1);
                     last_scan <= scan_r;
                     last_pos  <= in_pos;
                     if (in_range_s) begin
                        cg_sig[cg_s] <= 1'b1;
                     end
                  end
                  if (!in_range_s) begin
                     err_r <= 1'b1;
                  end
`ifdef COLLECT_ABSSUM_EN
                  abs_sum <= abs_sum + (ADDR_WIDTH+COEFF_WIDTH)'(abs_sat(in_coeff));
`endif
                  if (scan_r == last_idx_r) begin
                     state_r  <= ST_REPORT;
                     in_ready <= 1'b0;
                  end
               end
            end
            ST_REPORT: begin
               tu_done <= 1'b1;
               tu_err  <= err_r;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r  <= ST_IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coeff_tu_collect.sv
// Randomized bench for coeff_tu_collect checked against a per-TU arithmetic model.
// Define COLLECT_ABSSUM_EN for both RTL and bench to include abs_sum checks.
`timescale 1ns/1ps
module tb_coeff_tu_collect;

   localparam int CW   = 16;
   localparam int AW   = 10;
   localparam int NCG  = 64;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 tu_start;
   logic [2:0]           log2_size;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [CW-1:0] in_coeff;
   logic [AW-1:0]        in_pos;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [CW-1:0]        wr_data;
   logic                 tu_done;
   logic                 tu_err;
   logic [AW:0]          nz_count;
   logic [AW-1:0]        last_scan;
   logic [AW-1:0]        last_pos;
   logic [NCG-1:0]       cg_sig;
`ifdef COLLECT_ABSSUM_EN
   logic [AW+CW-1:0]     abs_sum;
`endif

   coeff_tu_collect dut (
      .clk       (clk),
      .rst       (rst),
      .tu_start  (tu_start),
      .log2_size (log2_size),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_coeff  (in_coeff),
      .in_pos    (in_pos),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .tu_done   (tu_done),
      .tu_err    (tu_err),
      .nz_count  (nz_count),
      .last_scan (last_scan),
      .last_pos  (last_pos),
      .cg_sig    (cg_sig)
`ifdef COLLECT_ABSSUM_EN
     ,.abs_sum   (abs_sum)
`endif
   );

   always #5 clk = ~clk;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   // Write/done monitor, sampled on the falling edge.
   logic [AW-1:0] wq_addr[$];
   logic [CW-1:0] wq_data[$];
   int            done_cnt = 0;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wq_addr.push_back(wr_addr);
         wq_data.push_back(wr_data);
      end
      if (tu_done === 1'b1) done_cnt++;
   end

   // Beats of the TU under test, in transfer (scan) order.
   int b_pos[$];
   int b_coeff[$];

   function automatic int rand_coeff();
      int v;
      v = int'($urandom_range(0, 65535)) - 32768;
      if (v == 0) v = 1;
      return v;
   endfunction

   task automatic build(input int lg, input int density, input bit shuffle, input bit bad_pos);
      int n;
      int j;
      int t;
      n = 1 << (2 * lg);
      b_pos.delete();
      b_coeff.delete();
      for (int i = 0; i < n; i++) begin
         b_pos.push_back(i);
         b_coeff.push_back((int'($urandom_range(0, 99)) < density) ? rand_coeff() : 0);
      end
      if (shuffle) begin
         for (int i = n - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = b_pos[i]; b_pos[i] = b_pos[j]; b_pos[j] = t;
         end
      end
      if (bad_pos && n < 1024) b_pos[$urandom_range(0, n - 1)] = n + int'($urandom_range(0, 1023 - n));
   endtask

   // Reference statistics straight from the TU geometry.
   task automatic model(input int lg, output longint nz, output longint ls, output longint lp,
                        output logic [63:0] cg, output longint asum, output bit err);
      int size;
      int p;
      int c;
      size = 1 << lg;
      nz = 0; ls = 0; lp = 0; cg = '0; asum = 0; err = 1'b0;
      for (int i = 0; i < b_pos.size(); i++) begin
         p = b_pos[i];
         c = b_coeff[i];
         if (p >= size * size) err = 1'b1;
         if (c != 0) begin
            nz++;
            ls = i;
            lp = p;
            if (p < size * size) cg[((p / size) / 4) * (size / 4) + (p % size) / 4] = 1'b1;
         end
         if (c == -32768) asum += 32767;
         else if (c < 0)  asum += -c;
         else             asum += c;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_tu(input string name, input int lg, input bit toggle);
      longint nz, ls, lp, asum;
      logic [63:0] cg;
      bit err;
      int base_w, base_d, nbad, nw;
      model(lg, nz, ls, lp, cg, asum, err);
      base_w = wq_addr.size();
      base_d = done_cnt;
      tu_start = 1'b1; log2_size = 3'(lg);
      step();
      tu_start = 1'b0;
      check({name, "/ready"}, 64'(in_ready), 64'd1);
      check({name, "/err_clr"}, 64'(tu_err), 64'd0);
      for (int i = 0; i < b_pos.size(); i++) begin
         if (toggle) begin
            in_valid = 1'b0; in_pos = AW'($urandom); in_coeff = CW'($urandom);
            step();
         end
         in_valid = 1'b1; in_pos = AW'(b_pos[i]); in_coeff = CW'(b_coeff[i]);
         step();
      end
      // Keep offering junk while the block reports; it must not be taken.
      in_pos = AW'($urandom); in_coeff = CW'($urandom_range(1, 100));
      check({name, "/last_wr"}, 64'(wr_en), 64'd1);
      check({name, "/done_early"}, 64'(tu_done), 64'd0);
      step();
      in_valid = 1'b0;
      check({name, "/done"}, 64'(tu_done), 64'd1);
      check({name, "/err"}, 64'(tu_err), 64'(err));
      check({name, "/nz"}, 64'(nz_count), 64'(nz));
      check({name, "/last_scan"}, 64'(last_scan), 64'(ls));
      check({name, "/last_pos"}, 64'(last_pos), 64'(lp));
      check({name, "/cg_sig"}, 64'(cg_sig), cg);
`ifdef COLLECT_ABSSUM_EN
      check({name, "/abs_sum"}, 64'(abs_sum), 64'(asum));
`endif
      step();
      step();
      check({name, "/done_pulse"}, 64'(tu_done), 64'd0);
      check({name, "/hold_nz"}, 64'(nz_count), 64'(nz));
      check({name, "/done_cnt"}, 64'(done_cnt - base_d), 64'd1);
      nw = wq_addr.size() - base_w;
      check({name, "/wr_cnt"}, 64'(nw), 64'(b_pos.size()));
      nbad = 0;
      for (int i = 0; i < b_pos.size() && i < nw; i++) begin
         if (wq_addr[base_w + i] !== AW'(b_pos[i]) || wq_data[base_w + i] !== CW'(b_coeff[i])) nbad++;
      end
      check({name, "/wr_data"}, 64'(nbad), 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_w, base_d, lg;
      rst = 1'b1; tu_start = 1'b0; log2_size = 3'd0; in_valid = 1'b0;
      in_coeff = '0; in_pos = '0;
      repeat (3) step();
      check("rst/ready", 64'(in_ready), 64'd0);
      check("rst/ctl", 64'({wr_en, tu_done, tu_err}), 64'd0);
      check("rst/stats", 64'(nz_count) | 64'(last_scan) | 64'(last_pos), 64'd0);
      check("rst/cg_sig", 64'(cg_sig), 64'd0);
      rst = 1'b0;
      step();

      // 4x4 directed: 5 at scan 0, -3 at scan 9.
      build(2, 0, 1'b0, 1'b0);
      b_coeff[0] = 5; b_coeff[9] = -3;
      run_tu("dir4x4", 2, 1'b0);
      check("dir4x4/nz_const", 64'(nz_count), 64'd2);
      check("dir4x4/cg_const", 64'(cg_sig), 64'd1);
`ifdef COLLECT_ABSSUM_EN
      check("dir4x4/abs_const", 64'(abs_sum), 64'd8);
`endif

      // 8x8 directed: only position 63 holds -1.
      build(3, 0, 1'b0, 1'b0);
      b_coeff[63] = -1;
      run_tu("dir8x8", 3, 1'b0);
      check("dir8x8/cg_const", 64'(cg_sig), 64'h8);
      check("dir8x8/last_const", 64'(last_scan), 64'd63);

      // 32x32 with valid toggling every other cycle.
      build(5, 10, 1'b1, 1'b0);
      run_tu("tog32", 5, 1'b1);

      // In-valid offered while idle must not transfer.
      base_w = wq_addr.size();
      in_valid = 1'b1; in_pos = 10'd7; in_coeff = 16'sd9;
      repeat (3) step();
      in_valid = 1'b0;
      step();
      check("idle/no_wr", 64'(wq_addr.size() - base_w), 64'd0);

      // Random TUs, some with positions outside the TU.
      for (int t = 0; t < 8; t++) begin
         lg = int'($urandom_range(2, 5));
         build(lg, int'($urandom_range(5, 60)), 1'b1, ($urandom_range(0, 2) == 0));
         run_tu($sformatf("rnd%0d", t), lg, 1'b0);
      end

      // Abort: restart request at beat 5 of an 8x8 TU.
      build(3, 40, 1'b0, 1'b0);
      base_w = wq_addr.size(); base_d = done_cnt;
      tu_start = 1'b1; log2_size = 3'd3;
      step();
      tu_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_pos = AW'(b_pos[i]); in_coeff = CW'(b_coeff[i]);
         step();
      end
      in_valid = 1'b0; tu_start = 1'b1; log2_size = 3'd2;
      step();
      tu_start = 1'b0;
      check("abort/ready", 64'(in_ready), 64'd0);
      check("abort/done_early", 64'(tu_done), 64'd0);
      step();
      check("abort/done", 64'(tu_done), 64'd1);
      check("abort/err", 64'(tu_err), 64'd1);
      step();
      check("abort/idle_ready", 64'(in_ready), 64'd0);
      check("abort/wr_cnt", 64'(wq_addr.size() - base_w), 64'd5);
      check("abort/done_cnt", 64'(done_cnt - base_d), 64'd1);

      // Unsupported sizes report an error with no writes.
      for (int k = 0; k < 2; k++) begin
         base_w = wq_addr.size();
         tu_start = 1'b1; log2_size = (k == 0) ? 3'd6 : 3'd1;
         step();
         tu_start = 1'b0;
         check("badsz/ready", 64'(in_ready), 64'd0);
         check("badsz/done_early", 64'(tu_done), 64'd0);
         step();
         check("badsz/done", 64'(tu_done), 64'd1);
         check("badsz/err", 64'(tu_err), 64'd1);
         check("badsz/nz", 64'(nz_count), 64'd0);
         step();
         check("badsz/wr_cnt", 64'(wq_addr.size() - base_w), 64'd0);
      end

      // Reset in the middle of an 8x8 TU, then a fresh 4x4 TU.
      build(3, 50, 1'b0, 1'b0);
      base_d = done_cnt;
      tu_start = 1'b1; log2_size = 3'd3;
      step();
      tu_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_pos = AW'(b_pos[i]); in_coeff = CW'(b_coeff[i]);
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #2;
      check("midrst/ready", 64'(in_ready), 64'd0);
      check("midrst/nz", 64'(nz_count), 64'd0);
      step();
      rst = 1'b0;
      repeat (4) step();
      check("midrst/no_done", 64'(done_cnt - base_d), 64'd0);
      build(2, 30, 1'b1, 1'b0);
      b_coeff[3] = -32768; b_coeff[7] = 100;
      run_tu("post_rst", 2, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
